// File: rtl/fetch_queue.sv
// Fetch stage owning the PC: issues one read per cycle, queues returned words with their PCs.
// Optional performance counters are enabled with `define FETCH_PERF_COUNT_EN.
module fetch_queue #(
    parameter int PC_WIDTH          = 32,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int QUEUE_DEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         PCSelector,
    input  logic [PC_WIDTH-1:0]          NewPC,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]          instruction_pc,
    output logic                         instruction_valid,
    input  logic                         instruction_ready,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  redirect_count
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QUEUE_DEPTH);

    logic [PC_WIDTH-1:0]          fetch_pc;
    logic                         inflight;
    logic [PC_WIDTH-1:0]          inflight_pc;
    logic [INSTRUCTION_WIDTH-1:0] word_mem [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0]          pc_mem   [QUEUE_DEPTH];
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [CNT_W-1:0]             count;

    logic             redirect;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] occupancy;

    // Handshake: the head entry transfers to decode in any cycle where
    // enable, instruction_valid and instruction_ready are all high and no
    // redirect is taken; valid never depends on ready.
    always_comb begin
        redirect  = enable & PCSelector;
        occupancy = count + CNT_W'(inflight);
        // Counting the in-flight read reserves its slot, so a return can never overflow.
        imem_req  = ~reset & enable & ~PCSelector & (occupancy < DEPTH);
        push      = inflight & ~redirect;
        pop       = enable & instruction_valid & instruction_ready & ~redirect;
    end

    assign imem_addr         = fetch_pc;
    assign instruction       = word_mem[rd_ptr];
    assign instruction_pc    = pc_mem[rd_ptr];
    assign instruction_valid = (count != '0);
    assign queue_count       = count;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + PC_WIDTH'(1);
            end else if (redirect) begin
                fetch_pc <= NewPC;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                word_mem[wr_ptr] <= imem_data;
                pc_mem[wr_ptr]   <= inflight_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (enable && instruction_valid && !instruction_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect && (redirect_count != '1)) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory model, scenario tasks and an in-order PC scoreboard.
module tb_fetch_queue;

    localparam int PCW = 32;
    localparam int IW  = 32;
    localparam int QD  = 4;
    localparam logic [31:0] RPC = 32'h10;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          PCSelector;
    logic [PCW-1:0] NewPC;
    logic          imem_req;
    logic [PCW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instruction;
    logic [PCW-1:0] instruction_pc;
    logic          instruction_valid;
    logic          instruction_ready;
    logic [$clog2(QD):0] queue_count;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   redirect_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [PCW-1:0] exp_q[$];
    logic [PCW-1:0] exp_pc;

    fetch_queue #(
        .PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW), .QUEUE_DEPTH(QD), .RESET_PC(RPC)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .PCSelector(PCSelector), .NewPC(NewPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .instruction(instruction), .instruction_pc(instruction_pc),
        .instruction_valid(instruction_valid), .instruction_ready(instruction_ready),
        .queue_count(queue_count)
`ifdef FETCH_PERF_COUNT_EN
        , .stall_cycles(stall_cycles), .redirect_count(redirect_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0000;
    endfunction

    // Memory answers one cycle after a request.
    always @(posedge clock) imem_data <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // Scoreboard: every accepted instruction must be the next expected PC and its word.
    always @(negedge clock) begin
        if (!reset && enable && !PCSelector && instruction_valid && instruction_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc %h, no delivery expected", instruction_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                if (instruction_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL sb_order: got pc %h word %h, want pc %h word %h",
                             instruction_pc, instruction, exp_pc, mem_word(exp_pc));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic push_run(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i));
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; PCSelector = 1'b0; NewPC = '0; instruction_ready = 1'b1;
        exp_q.delete();
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req_async: got %b want 0", imem_req); end
        tick;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++;
        if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
        checks++;
        if (instruction_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instruction_valid); end
        checks++;
        if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", queue_count); end
        checks++;
        if (instruction !== 32'h0 || instruction_pc !== 32'h0) begin
            errors++; $display("FAIL reset_head: got %h/%h want 0/0", instruction, instruction_pc);
        end
`ifdef FETCH_PERF_COUNT_EN
        checks++;
        if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cycles, redirect_count);
        end
`endif
        tick;
    endtask

    task automatic test_stream;
        reset = 1'b0;
        push_run(RPC);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checks++;
            if (imem_addr !== RPC + 32'(k) || imem_req !== 1'b1) begin
                errors++; $display("FAIL stream_issue c%0d: got %h/%b want %h/1", k, imem_addr, imem_req, RPC + 32'(k));
            end
            checks++;
            if (instruction_valid !== (k >= 2)) begin
                errors++; $display("FAIL stream_valid c%0d: got %b want %b", k, instruction_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (instruction_pc !== RPC + 32'(k - 2)) begin
                    errors++; $display("FAIL stream_pc c%0d: got %h want %h", k, instruction_pc, RPC + 32'(k - 2));
                end
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        instruction_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checks++;
            if (queue_count !== ((k < 3) ? 3'(k + 1) : 3'd4)) begin
                errors++; $display("FAIL bp_count c%0d: got %0d want %0d", k, queue_count, (k < 3) ? k + 1 : 4);
            end
            checks++;
            if (imem_req !== (k < 2)) begin
                errors++; $display("FAIL bp_req c%0d: got %b want %b", k, imem_req, k < 2);
            end
            checks++;
            if (instruction_pc !== 32'h18) begin
                errors++; $display("FAIL bp_head c%0d: got %h want 00000018", k, instruction_pc);
            end
            tick;
        end
        instruction_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            checks++;
            if (instruction_valid !== 1'b1) begin
                errors++; $display("FAIL drain_valid c%0d: got %b want 1", k, instruction_valid);
            end
            if (k == 0) begin
                checks++;
                if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req0: got %b want 0", imem_req); end
            end
            if (k == 1) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h1C) begin
                    errors++; $display("FAIL drain_resume: got %b/%h want 1/0000001c", imem_req, imem_addr);
                end
            end
            tick;
        end
    endtask

    task automatic test_redirect;
        instruction_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (queue_count !== 3'd2) begin errors++; $display("FAIL redir_pre: got %0d want 2", queue_count); end
        tick;
        PCSelector = 1'b1; NewPC = 32'h200; instruction_ready = 1'b1;
        push_run(32'h200);
        @(negedge clock);
        checks++;
        if (queue_count !== 3'd3 || imem_req !== 1'b0) begin
            errors++; $display("FAIL redir_cycle: got count %0d req %b want 3/0", queue_count, imem_req);
        end
        tick;
        PCSelector = 1'b0;
        @(negedge clock);
        checks++;
        if (queue_count !== 3'd0 || imem_addr !== 32'h200 || imem_req !== 1'b1 || instruction_valid !== 1'b0) begin
            errors++; $display("FAIL redir_r1: got count %0d addr %h req %b valid %b want 0/200/1/0",
                               queue_count, imem_addr, imem_req, instruction_valid);
        end
        tick;
        @(negedge clock);
        checks++;
        if (instruction_valid !== 1'b0 || imem_addr !== 32'h201) begin
            errors++; $display("FAIL redir_r2: got valid %b addr %h want 0/201", instruction_valid, imem_addr);
        end
        tick;
        @(negedge clock);
        checks++;
        if (instruction_valid !== 1'b1 || instruction_pc !== 32'h200 || instruction !== mem_word(32'h200)) begin
            errors++; $display("FAIL redir_r3: got valid %b pc %h word %h want 1/200/%h",
                               instruction_valid, instruction_pc, instruction, mem_word(32'h200));
        end
        tick;
    endtask

    task automatic test_enable_freeze;
        repeat (4) tick;
        enable = 1'b0; PCSelector = 1'b1; NewPC = 32'h7777;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if (imem_addr !== 32'h207 || imem_req !== 1'b0) begin
                errors++; $display("FAIL freeze_pc c%0d: got %h/%b want 207/0", k, imem_addr, imem_req);
            end
            checks++;
            if (instruction_pc !== 32'h205 || instruction !== mem_word(32'h205)) begin
                errors++; $display("FAIL freeze_head c%0d: got %h/%h want 205/%h", k, instruction_pc, instruction, mem_word(32'h205));
            end
            checks++;
            if (queue_count !== ((k == 0) ? 3'd1 : 3'd2)) begin
                errors++; $display("FAIL freeze_count c%0d: got %0d want %0d", k, queue_count, (k == 0) ? 1 : 2);
            end
            tick;
        end
        enable = 1'b1; PCSelector = 1'b0;
        @(negedge clock);
        checks++;
        if (imem_addr !== 32'h207 || imem_req !== 1'b1) begin
            errors++; $display("FAIL freeze_release: got %h/%b want 207/1", imem_addr, imem_req);
        end
        tick;
        repeat (6) tick;
    endtask

    task automatic test_wrap;
        PCSelector = 1'b1; NewPC = 32'hFFFF_FFFF;
        push_run(32'hFFFF_FFFF);
        tick;
        PCSelector = 1'b0;
        @(negedge clock);
        checks++;
        if (imem_addr !== 32'hFFFF_FFFF || imem_req !== 1'b1) begin
            errors++; $display("FAIL wrap_max: got %h/%b want ffffffff/1", imem_addr, imem_req);
        end
        tick;
        @(negedge clock);
        checks++;
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", imem_addr); end
        tick;
        repeat (6) tick;
    endtask

`ifdef FETCH_PERF_COUNT_EN
    task automatic test_perf;
        reset = 1'b1; enable = 1'b1; PCSelector = 1'b0; instruction_ready = 1'b1;
        exp_q.delete();
        tick;
        reset = 1'b0;
        push_run(RPC);
        tick; tick;
        instruction_ready = 1'b0;
        repeat (7) tick;
        instruction_ready = 1'b1;
        PCSelector = 1'b1; NewPC = 32'h300; push_run(32'h300);
        tick;
        PCSelector = 1'b0;
        tick;
        PCSelector = 1'b1; NewPC = 32'h400; push_run(32'h400);
        tick;
        PCSelector = 1'b0;
        tick; tick;
        @(negedge clock);
        checks++;
        if (stall_cycles !== 32'd7) begin errors++; $display("FAIL perf_stall: got %0d want 7", stall_cycles); end
        checks++;
        if (redirect_count !== 32'd2) begin errors++; $display("FAIL perf_redirect: got %0d want 2", redirect_count); end
        tick;
        reset = 1'b1;
        exp_q.delete();
        tick;
        @(negedge clock);
        checks++;
        if (stall_cycles !== 32'd0 || redirect_count !== 32'd0) begin
            errors++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, redirect_count);
        end
        tick;
        reset = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b1; PCSelector = 1'b0; NewPC = '0; instruction_ready = 1'b1;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_enable_freeze;
        test_wrap;
        test_reset;
        test_stream;
`ifdef FETCH_PERF_COUNT_EN
        test_perf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
